key_press_detect: RTL
=====================

Name: key_press_detect

Overview:
- Multi-channel key front end and successor to the single-mode debounce FSM.
- Per channel: synchronises the raw active-low key, debounces both press and release, and drives a clean debounced level.
- Per channel: classifies each press as short or long and, when enabled, generates auto-repeat pulses while a key is held.
- Sits between the board key pins and the application control logic. All channels are independent.

Parameters:
- W, 3: number of key channels.
- TIME_DEB, 1_000_000: debounce window in clk cycles (20 ms at 50 MHz); must be >= 2.
- TIME_LONG, 50_000_000: long-press threshold in clk cycles, counted from debounced press; must be >= 2.
- TIME_REP, 10_000_000: auto-repeat interval in clk cycles; must be >= 2.
- REP_EN, 0: 1 enables key_rep generation; 0 holds key_rep at 0.
- CNT_W, 26: counter width; must satisfy 2^CNT_W > max(TIME_DEB, TIME_LONG, TIME_REP).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- key_in  input  W  raw keys, active-low (0 = pressed), asynchronous to clk.
- key_level  output  W  debounced level, active-low, registered.
- key_short  output  W  1-cycle pulse: press released before the long threshold.
- key_long  output  W  1-cycle pulse: press held to the long threshold.
- key_rep  output  W  1-cycle pulse every TIME_REP while held after key_long (REP_EN=1 only).

Behaviour:
- Reset is asynchronous and active-low, one clock. On reset:
  - sync flops are all ones;
  - every channel goes to IDLE with all counters at 0 and long_flag at 0;
  - key_level is all ones;
  - key_short, key_long and key_rep are 0.
- Reset mid-operation aborts any press in progress with no pulse emitted.
- Sync: two flops per channel (s0, s1). fall = ~s0 & s1; rise = s0 & ~s1.
- Per channel, a one-hot FSM with states IDLE, DOWN, HOLD, UP:
  - a debounce counter dcnt;
  - a hold counter hcnt;
  - a long_flag.
- IDLE: on fall -> DOWN; dcnt = 0.
- DOWN: dcnt increments each cycle.
  - rise before the end of the window -> IDLE, no outputs (glitch rejected).
  - dcnt == TIME_DEB-1 with no rise that cycle -> HOLD.
  - Entering HOLD: key_level[i] <= 0, hcnt = 0, long_flag = 0.
  - rise and end of window in the same cycle -> IDLE (rise wins).
- HOLD: hcnt increments.
  - While long_flag = 0: hcnt == TIME_LONG-1 -> key_long[i] pulses next cycle, long_flag = 1, hcnt = 0.
  - key_long therefore pulses exactly TIME_LONG cycles after key_level[i] falls.
  - While long_flag = 1 and REP_EN = 1: hcnt wraps at TIME_REP-1 and key_rep[i] pulses on each wrap, i.e. TIME_REP, 2*TIME_REP, ... cycles after key_long.
  - While long_flag = 1 and REP_EN = 0: hcnt holds.
  - rise -> UP; dcnt = 0. hcnt and long_flag are preserved.
- UP: dcnt increments.
  - fall before the end of the window -> back to HOLD, treated as release bounce. No pulse, key_level stays 0, hcnt continues from its preserved value.
  - dcnt == TIME_DEB-1 with no fall -> IDLE, key_level[i] <= 1.
  - key_short[i] pulses in that same cycle if long_flag = 0.
  - fall and end of window in the same cycle -> HOLD (fall wins).
- While in UP, hcnt is frozen: no key_long or key_rep pulses are issued.
- Per press: exactly one of key_short or key_long is produced, never both.
- All outputs are registered. Pulses are exactly 1 cycle wide.
- Channels are fully independent; simultaneous events on different channels are each handled in the same cycle.

Test Plan (TIME_DEB=4, TIME_LONG=20, TIME_REP=8 unless noted):
- Glitch: key_in[0] low for 2 cycles, then high -> key_level stays 3'b111; no pulses on any output.
- Short press: key_in[0] low 15 cycles, then high -> key_level[0] low for a bounded window; exactly one key_short[0] pulse, coincident with key_level[0] rising; no key_long.
- Long press, REP_EN=0: key_in[1] low 60 cycles -> one key_long[1] pulse exactly 20 cycles after key_level[1] falls; no key_short on release; key_rep = 0.
- Auto-repeat, REP_EN=1: key_in[2] low 60 cycles -> key_long[2] pulse at t; key_rep[2] pulses at t+8, t+16, t+24, t+32 only while HOLD remains (none after rise); no key_short.
- Release bounce: held 30 cycles, then 1-cycle high/low chatter twice before a clean high -> single release; no extra pulses; key_long count stays 1.
- Multi-channel and reset: ch0 short press overlapping ch1 long press, both correct; assert rst_n low mid-HOLD on ch1 -> outputs return to reset values immediately; no pulse after rst_n rises while the key is still low until a new fall edge is seen.

Source files
------------

// File: rtl/key_press_detect.sv
// key_press_detect: multi-channel key front end.
// Each channel synchronises a raw active-low key, debounces press and release,
// drives a clean debounced level, classifies each press as short or long and,
// when REP_EN is set, emits auto-repeat pulses while a long press is held.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   key_in     [W] raw keys, active-low, asynchronous to clk
//   key_level  [W] debounced level, active-low, registered
//   key_short  [W] 1-cycle pulse: released before the long threshold
//   key_long   [W] 1-cycle pulse: held to the long threshold
//   key_rep    [W] 1-cycle pulse every TIME_REP cycles after key_long (REP_EN=1)
module key_press_detect #(
  parameter int unsigned W         = 3,
  parameter int unsigned TIME_DEB  = 1_000_000,
  parameter int unsigned TIME_LONG = 50_000_000,
  parameter int unsigned TIME_REP  = 10_000_000,
  parameter int unsigned REP_EN    = 0,
  parameter int unsigned CNT_W     = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] key_in,
  output logic [W-1:0] key_level,
  output logic [W-1:0] key_short,
  output logic [W-1:0] key_long,
  output logic [W-1:0] key_rep
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    DOWN = 4'b0010,
    HOLD = 4'b0100,
    UP   = 4'b1000
  } state_t;

  localparam logic [CNT_W-1:0] DEB_END  = CNT_W'(TIME_DEB - 1);
  localparam logic [CNT_W-1:0] LONG_END = CNT_W'(TIME_LONG - 1);
  localparam logic [CNT_W-1:0] REP_END  = CNT_W'(TIME_REP - 1);
  localparam bit               REP_ON   = (REP_EN != 0);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_ch
      logic             r_s0;
      logic             r_s1;
      state_t           r_state;
      logic [CNT_W-1:0] r_dcnt;
      logic [CNT_W-1:0] r_hcnt;
      logic             r_long_flag;
      logic             r_level;
      logic             r_short;
      logic             r_long;
      logic             r_rep;
      logic             w_fall;
      logic             w_rise;

      // Edges are taken between the two sync flops (s0 is the newer sample).
      assign w_fall = ~r_s0 & r_s1;
      assign w_rise = r_s0 & ~r_s1;

      // Two-flop synchroniser; resets to the released (high) level.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s0 <= 1'b1;
          r_s1 <= 1'b1;
        end else begin
          r_s0 <= key_in[gi];
          r_s1 <= r_s0;
        end
      end

      // Press/release debounce and short/long/repeat classification.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state     <= IDLE;
          r_dcnt      <= '0;
          r_hcnt      <= '0;
          r_long_flag <= 1'b0;
          r_level     <= 1'b1;
          r_short     <= 1'b0;
          r_long      <= 1'b0;
          r_rep       <= 1'b0;
        end else begin
          r_short <= 1'b0;
          r_long  <= 1'b0;
          r_rep   <= 1'b0;
          case (r_state)
            IDLE: begin
              if (w_fall) begin
                r_state <= DOWN;
                r_dcnt  <= '0;
              end
            end
            DOWN: begin
              // A rise anywhere in the window, including its last cycle, is a glitch.
              if (w_rise) begin
                r_state <= IDLE;
              end else if (r_dcnt == DEB_END) begin
                r_state     <= HOLD;
                r_level     <= 1'b0;
                r_hcnt      <= '0;
                r_long_flag <= 1'b0;
              end else begin
                r_dcnt <= r_dcnt + CNT_W'(1);
              end
            end
            HOLD: begin
              if (w_rise) begin
                r_state <= UP;
                r_dcnt  <= '0;
              end else if (!r_long_flag) begin
                if (r_hcnt == LONG_END) begin
                  r_long      <= 1'b1;
                  r_long_flag <= 1'b1;
                  r_hcnt      <= '0;
                end else begin
                  r_hcnt <= r_hcnt + CNT_W'(1);
                end
              end else if (REP_ON) begin
                if (r_hcnt == REP_END) begin
                  r_rep  <= 1'b1;
                  r_hcnt <= '0;
                end else begin
                  r_hcnt <= r_hcnt + CNT_W'(1);
                end
              end
            end
            UP: begin
              // A fall during release debounce is bounce: resume HOLD, hcnt untouched.
              if (w_fall) begin
                r_state <= HOLD;
              end else if (r_dcnt == DEB_END) begin
                r_state <= IDLE;
                r_level <= 1'b1;
                r_short <= ~r_long_flag;
              end else begin
                r_dcnt <= r_dcnt + CNT_W'(1);
              end
            end
            default: begin
              r_state <= IDLE;
            end
          endcase
        end
      end

      assign key_level[gi] = r_level;
      assign key_short[gi] = r_short;
      assign key_long[gi]  = r_long;
      assign key_rep[gi]   = r_rep;
    end
  endgenerate

endmodule
